// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD bus arbiter.
// Holds the controller state encoding, the HD44780-style command bytes used
// by the init sequence, and the test for commands that need the long hold.
package lcd_pkg;

    typedef enum logic [3:0] {
        ST_INIT_WAIT  = 4'd0,
        ST_INIT_FS    = 4'd1,
        ST_INIT_DISP  = 4'd2,
        ST_INIT_ENTRY = 4'd3,
        ST_INIT_CLR   = 4'd4,
        ST_IDLE       = 4'd5,
        ST_XFER       = 4'd6,
        ST_HOLD       = 4'd7,
        ST_POLL       = 4'd8
    } lcd_state_e;

    localparam logic [7:0] LCD_FUNC_SET = 8'h3C;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_HOME     = 8'h02;

    // Clear (0x01) and home (0x02/0x03) are the only instructions with the
    // multi-millisecond execution time; everything else is fast.
    function automatic logic is_long_cmd(input logic rs_v, input logic [7:0] data_v);
        return (!rs_v) && (data_v[7:2] == 6'd0) && (data_v[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/lcd_slot_timer.sv
// Bus slot timing for the LCD arbiter.
// A slot is 2*CLK_DIV clocks: the first half has e low, the second half e
// high, so the LCD sees a falling e edge at the end of every pulsed slot.
// A slot down-counter measures waits (power-on wait, command gap, clear hold)
// in whole slots; it starts loaded with the power-on wait.
module lcd_slot_timer #(
    parameter int CLK_DIV   = 5,
    parameter int INIT_WAIT = 70,
    parameter int WAIT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run_i,
    input  logic              load_i,
    input  logic [WAIT_W-1:0] load_val_i,
    output logic              slot_end_o,
    output logic              e_phase_o,
    output logic              wait_last_o
);

    localparam int CNT_W = $clog2(2 * CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * CLK_DIV - 1);
    localparam logic [CNT_W-1:0] PHASE_HI = CNT_W'(CLK_DIV);

    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              phase_q;
    logic [WAIT_W-1:0] wait_q;

    // Next slot count: held at zero while stopped, wraps at the slot end.
    always_comb begin
        cnt_d = cnt_q;
        if (!run_i) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign slot_end_o  = run_i && (cnt_q == CNT_LAST);
    assign e_phase_o   = phase_q;
    assign wait_last_o = (wait_q == WAIT_W'(1));

    // Slot counter and registered e phase (high in the second half-slot).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= (cnt_d >= PHASE_HI);
        end
    end

    // Wait down-counter: reload wins over the per-slot decrement.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_q <= WAIT_W'(INIT_WAIT);
        end else if (load_i) begin
            wait_q <= load_val_i;
        end else if (slot_end_o && (wait_q != '0)) begin
            wait_q <= wait_q - 1'b1;
        end
    end

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Character-LCD bus owner: runs the power-on init sequence, then shares the
// bus between two requesters with round-robin arbitration and enforces the
// per-command wait after each write.
//
// Optional build macro LCD_BUSY_POLL_EN: replaces the fixed post-command wait
// with busy-flag polling (adds busy_flag input and data_oe output).
//
// state         | meaning
// --------------+----------------------------------------------------------
// ST_INIT_WAIT  | power-on wait, INIT_WAIT idle slots
// ST_INIT_FS    | init write: function set 0x3C
// ST_INIT_DISP  | init write: display on 0x0C
// ST_INIT_ENTRY | init write: entry mode 0x06
// ST_INIT_CLR   | init write: clear 0x01
// ST_IDLE       | init complete, waiting for a request
// ST_XFER       | one write slot with the granted byte
// ST_HOLD       | fixed wait, CMD_GAP or CLEAR_HOLD slots
// ST_POLL       | busy-flag read slots until the LCD reports ready
//
// The grant clock counts as slot count 0 of the transfer, so a normal write
// plus its gap takes exactly (1+CMD_GAP) slots from grant to next grant.
module lcd_bus_arbiter
    import lcd_pkg::*;
#(
    parameter int CLK_DIV    = 5,
    parameter int INIT_WAIT  = 70,
    parameter int CMD_GAP    = 1,
    parameter int CLEAR_HOLD = 200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [1:0]  req_rs,
    input  logic [15:0] req_data,
`ifdef LCD_BUSY_POLL_EN
    input  logic        busy_flag,
    output logic        data_oe,
`endif
    output logic [1:0]  gnt,
    output logic        busy,
    output logic        init_done,
    output logic        e,
    output logic        rs,
    output logic        rw,
    output logic [7:0]  data
);

    localparam int WAIT_W = 16;

`ifdef LCD_BUSY_POLL_EN
    localparam lcd_state_e WAIT_ST    = ST_POLL;
    localparam logic       WAIT_RS    = 1'b0;
    localparam logic       WAIT_PULSE = 1'b1;
`else
    localparam lcd_state_e WAIT_ST    = ST_HOLD;
    localparam logic       WAIT_RS    = 1'b1;
    localparam logic       WAIT_PULSE = 1'b0;
`endif

    lcd_state_e  state_q;
    logic        rr_q;
    logic        rs_q;
    logic        rw_q;
    logic [7:0]  data_q;
    logic        pulse_q;
    logic        busy_q;
    logic        init_done_q;

    logic              slot_end;
    logic              e_phase;
    logic              wait_last;
    logic              run;
    logic              hold_load;
    logic [WAIT_W-1:0] hold_len;

    logic        grant_en;
    logic        win_idx;
    logic        win_rs;
    logic [7:0]  win_data;

    // Round-robin pick: rr_q names the requester that wins a tie.
    always_comb begin
        grant_en = (state_q == ST_IDLE) && (req != 2'b00);
        win_idx  = (req == 2'b11) ? rr_q : req[1];
        win_rs   = req_rs[win_idx];
        win_data = win_idx ? req_data[15:8] : req_data[7:0];
        gnt      = 2'b00;
        if (grant_en) begin
            gnt = win_idx ? 2'b10 : 2'b01;
        end
    end

    // Timer control: counting stops only while idle with nothing to grant;
    // the wait length is chosen from the byte still on the bus at slot end.
    always_comb begin
        run       = (state_q != ST_IDLE) || grant_en;
        hold_load = slot_end && ((state_q == ST_XFER) || (state_q == ST_INIT_CLR));
        hold_len  = is_long_cmd(rs_q, data_q) ? WAIT_W'(CLEAR_HOLD) : WAIT_W'(CMD_GAP);
    end

    lcd_slot_timer #(
        .CLK_DIV   (CLK_DIV),
        .INIT_WAIT (INIT_WAIT),
        .WAIT_W    (WAIT_W)
    ) u_slot_timer (
        .clk         (clk),
        .reset       (reset),
        .run_i       (run),
        .load_i      (hold_load),
        .load_val_i  (hold_len),
        .slot_end_o  (slot_end),
        .e_phase_o   (e_phase),
        .wait_last_o (wait_last)
    );

    // Controller FSM with registered bus outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_INIT_WAIT;
            rr_q        <= 1'b0;
            rs_q        <= 1'b1;
            rw_q        <= 1'b1;
            data_q      <= 8'h00;
            pulse_q     <= 1'b0;
            busy_q      <= 1'b1;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT_WAIT: begin
                    if (slot_end && wait_last) begin
                        state_q <= ST_INIT_FS;
                        rs_q    <= 1'b0;
                        rw_q    <= 1'b0;
                        data_q  <= LCD_FUNC_SET;
                        pulse_q <= 1'b1;
                    end
                end
                ST_INIT_FS: begin
                    if (slot_end) begin
                        state_q <= ST_INIT_DISP;
                        data_q  <= LCD_DISP_ON;
                    end
                end
                ST_INIT_DISP: begin
                    if (slot_end) begin
                        state_q <= ST_INIT_ENTRY;
                        data_q  <= LCD_ENTRY;
                    end
                end
                ST_INIT_ENTRY: begin
                    if (slot_end) begin
                        state_q <= ST_INIT_CLR;
                        data_q  <= LCD_CLEAR;
                    end
                end
                ST_INIT_CLR, ST_XFER: begin
                    if (slot_end) begin
                        state_q <= WAIT_ST;
                        rs_q    <= WAIT_RS;
                        rw_q    <= 1'b1;
                        data_q  <= 8'h00;
                        pulse_q <= WAIT_PULSE;
                    end
                end
                ST_IDLE: begin
                    if (grant_en) begin
                        state_q <= ST_XFER;
                        rs_q    <= win_rs;
                        rw_q    <= 1'b0;
                        data_q  <= win_data;
                        pulse_q <= 1'b1;
                        busy_q  <= 1'b1;
                        rr_q    <= ~win_idx;
                    end
                end
                ST_HOLD: begin
                    if (slot_end && wait_last) begin
                        state_q     <= ST_IDLE;
                        rs_q        <= 1'b1;
                        rw_q        <= 1'b1;
                        data_q      <= 8'h00;
                        pulse_q     <= 1'b0;
                        busy_q      <= 1'b0;
                        init_done_q <= 1'b1;
                    end
                end
`ifdef LCD_BUSY_POLL_EN
                ST_POLL: begin
                    if (slot_end && !busy_flag) begin
                        state_q     <= ST_IDLE;
                        rs_q        <= 1'b1;
                        rw_q        <= 1'b1;
                        data_q      <= 8'h00;
                        pulse_q     <= 1'b0;
                        busy_q      <= 1'b0;
                        init_done_q <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_q <= ST_INIT_WAIT;
                end
            endcase
        end
    end

    assign e         = pulse_q & e_phase;
    assign rs        = rs_q;
    assign rw        = rw_q;
    assign data      = data_q;
    assign busy      = busy_q;
    assign init_done = init_done_q;

`ifdef LCD_BUSY_POLL_EN
    // The block only drives the data pins on write slots.
    assign data_oe = ~rw_q;
`endif

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Directed bench for lcd_bus_arbiter with default parameters.
// Cycle k is the clock period after the k-th rising edge since reset release.
module tb_lcd_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [1:0]  req_rs = 2'b00;
    logic [15:0] req_data = 16'h0000;
    logic [1:0]  gnt;
    logic        busy;
    logic        init_done;
    logic        e;
    logic        rs;
    logic        rw;
    logic [7:0]  data;
`ifdef LCD_BUSY_POLL_EN
    logic        busy_flag = 1'b0;
    logic        data_oe;
`endif

    lcd_bus_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_rs    (req_rs),
        .req_data  (req_data),
`ifdef LCD_BUSY_POLL_EN
        .busy_flag (busy_flag),
        .data_oe   (data_oe),
`endif
        .gnt       (gnt),
        .busy      (busy),
        .init_done (init_done),
        .e         (e),
        .rs        (rs),
        .rw        (rw),
        .data      (data)
    );

    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Event log: e rising edges with the bus contents, and grants.
    int         rise_cyc[$];
    int         rise_dat[$];
    int         rise_rs[$];
    int         rise_rw[$];
    int         gnt_cyc[$];
    int         gnt_val[$];
    logic       e_prev = 1'b0;

    always @(negedge clk) begin
        if (e && !e_prev) begin
            rise_cyc.push_back(cyc);
            rise_dat.push_back(int'(data));
            rise_rs.push_back(int'(rs));
            rise_rw.push_back(int'(rw));
        end
        if (gnt != 2'b00) begin
            gnt_cyc.push_back(cyc);
            gnt_val.push_back(int'(gnt));
            check_val("gnt_onehot", $countones(gnt), 1);
            check_val("gnt_busy_low", busy, 0);
        end
        e_prev = e;
    end

    function automatic int q_get(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic clear_log();
        rise_cyc.delete();
        rise_dat.delete();
        rise_rs.delete();
        rise_rw.delete();
        gnt_cyc.delete();
        gnt_val.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int target);
        int guard;
        guard = 0;
        while (cyc < target && guard < 20000) begin
            tick();
            guard++;
        end
        check_val("run_to_reached", cyc, target);
    endtask

    task automatic check_rise(input string tag, input int i, input int exp_cyc,
                              input int exp_dat, input int exp_rs);
        check_val({tag, "_cyc"}, q_get(rise_cyc, i), exp_cyc);
        check_val({tag, "_data"}, q_get(rise_dat, i), exp_dat);
        check_val({tag, "_rs"}, q_get(rise_rs, i), exp_rs);
        check_val({tag, "_rw"}, q_get(rise_rw, i), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_e"}, e, 0);
        check_val({tag, "_rs"}, rs, 1);
        check_val({tag, "_rw"}, rw, 1);
        check_val({tag, "_data"}, data, 0);
        check_val({tag, "_gnt"}, gnt, 0);
        check_val({tag, "_busy"}, busy, 1);
        check_val({tag, "_init_done"}, init_done, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int init_cmd[4];
    int exp_gcyc[10];
    int exp_gval[10];

    initial begin
        init_cmd = '{32'h3C, 32'h0C, 32'h06, 32'h01};
        exp_gcyc = '{2740, 2760, 2780, 2800, 2820, 4830, 4850, 6860, 6880, 6900};
        exp_gval = '{1, 2, 1, 2, 2, 1, 1, 2, 1, 2};

        // ---- Run A: init sequence, early request held off until init_done
        repeat (2) tick();
        check_reset_outputs("rst");
        reset = 1'b1;
        run_to(100);
        req_rs   = 2'b01;
        req_data = 16'h0041;
        req      = 2'b01;
        run_to(2739);
        check_val("pre_init_busy", busy, 1);
        check_val("pre_init_done", init_done, 0);
        check_val("pre_init_gnt", gnt, 0);
        run_to(2740);
        check_val("init_done_rise", init_done, 1);
        check_val("idle_busy", busy, 0);
        check_val("first_gnt", gnt, 2'b01);
        tick();
        req = 2'b00;
        check_val("xfer_busy", busy, 1);
        run_to(2750);
        check_val("hold_e", e, 0);
        check_val("hold_rs", rs, 1);
        check_val("hold_rw", rw, 1);
        check_val("hold_data", data, 0);
        check_val("a_gnt_count", gnt_cyc.size(), 1);
        check_val("a_gnt_cyc", q_get(gnt_cyc, 0), 2740);
        for (int i = 0; i < 4; i++) begin
            check_rise($sformatf("init%0d", i), i, 705 + 10 * i, init_cmd[i], 0);
        end
        check_rise("a_write", 4, 2745, 32'h41, 1);

        // ---- Run B: round-robin, long/short holds, reset during a transfer
        reset = 1'b0;
        clear_log();
        req      = 2'b11;
        req_rs   = 2'b11;
        req_data = 16'hA1B2;
        repeat (3) tick();
        reset = 1'b1;
        run_to(2801);
        req      = 2'b10;
        req_rs   = 2'b00;
        req_data = 16'h0104;
        run_to(2821);
        req = 2'b01;
        run_to(4831);
        req_data[7:0] = 8'h02;
        run_to(4851);
        req             = 2'b10;
        req_rs          = 2'b10;
        req_data[15:8]  = 8'h55;
        run_to(6861);
        req           = 2'b01;
        req_rs        = 2'b11;
        req_data[7:0] = 8'h01;
        run_to(6881);
        req = 2'b10;
        run_to(6901);
        req           = 2'b01;
        req_data[7:0] = 8'h77;
        run_to(6906);
        check_val("mid_xfer_e", e, 1);
        check_val("mid_xfer_data", data, 8'h55);
        check_val("mid_xfer_rs", rs, 1);
        check_val("mid_xfer_rw", rw, 0);
        check_val("b_gnt_count", gnt_cyc.size(), 10);
        for (int i = 0; i < 10; i++) begin
            check_val($sformatf("b_gnt%0d_cyc", i), q_get(gnt_cyc, i), exp_gcyc[i]);
            check_val($sformatf("b_gnt%0d_val", i), q_get(gnt_val, i), exp_gval[i]);
        end
        check_rise("b_rr0", 4, 2745, 32'hB2, 1);
        check_rise("b_rr1", 5, 2765, 32'hA1, 1);
        check_rise("b_clear", 8, 2825, 32'h01, 0);
        check_rise("b_entry", 9, 4835, 32'h04, 0);
        check_rise("b_home", 10, 4855, 32'h02, 0);

        reset = 1'b0;
        #1;
        check_reset_outputs("midrst");
        clear_log();
        repeat (3) tick();
        reset = 1'b1;

        // ---- Run C: pending request survives the re-init and waits for it
        run_to(2739);
        check_val("c_no_early_gnt", gnt_cyc.size(), 0);
        check_val("c_pre_init_done", init_done, 0);
        run_to(2740);
        check_val("c_init_done", init_done, 1);
        check_val("c_gnt", gnt, 2'b01);
        tick();
        req = 2'b00;
        run_to(2750);
        check_rise("c_init0", 0, 705, 32'h3C, 0);
        check_rise("c_write", 4, 2745, 32'h77, 1);
        check_val("c_gnt_count", gnt_cyc.size(), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
